// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: vector constants, payload field
// layout, and the {skid_valid, main_valid} state encoding used by the stage.
package pipe_pkg;

  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PIPE_EXC_PC   = 32'h0000_4180;

  localparam int PAYLOAD_W = 160;
  localparam int M2R_W     = 3;
  localparam int RW_W      = 1;
  localparam int MD_W      = 32;
  localparam int AO_W      = 32;
  localparam int WA_W      = 5;
  localparam int HILO_W    = 32;
  localparam int CP0_W     = 32;
  localparam int FIELDS_W  = M2R_W + RW_W + MD_W + AO_W + WA_W + HILO_W + CP0_W;
  localparam int PAD_W     = PAYLOAD_W - FIELDS_W;

  localparam int CP0_LSB  = 0;
  localparam int HILO_LSB = CP0_LSB + CP0_W;
  localparam int WA_LSB   = HILO_LSB + HILO_W;
  localparam int AO_LSB   = WA_LSB + WA_W;
  localparam int MD_LSB   = AO_LSB + AO_W;
  localparam int RW_LSB   = MD_LSB + MD_W;
  localparam int M2R_LSB  = RW_LSB + RW_W;
  localparam int PAD_LSB  = M2R_LSB + M2R_W;

  typedef struct packed {
    logic [PAD_W-1:0]  pad;
    logic [M2R_W-1:0]  mem_to_reg;
    logic              reg_write;
    logic [MD_W-1:0]   md;
    logic [AO_W-1:0]   ao;
    logic [WA_W-1:0]   wa;
    logic [HILO_W-1:0] hilo;
    logic [CP0_W-1:0]  cp0;
  } payload_t;

  // Encoding is {skid_valid, main_valid}; ST_BAD must never be reachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_BAD   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_t;

  function automatic stage_state_t stage_state(input logic main_valid, input logic skid_valid);
    return stage_state_t'({skid_valid, main_valid});
  endfunction

  function automatic payload_t pack_payload(
    input logic [M2R_W-1:0]  mem_to_reg,
    input logic              reg_write,
    input logic [MD_W-1:0]   md,
    input logic [AO_W-1:0]   ao,
    input logic [WA_W-1:0]   wa,
    input logic [HILO_W-1:0] hilo,
    input logic [CP0_W-1:0]  cp0
  );
    payload_t p;
    p.pad        = '0;
    p.mem_to_reg = mem_to_reg;
    p.reg_write  = reg_write;
    p.md         = md;
    p.ao         = ao;
    p.wa         = wa;
    p.hilo       = hilo;
    p.cp0        = cp0;
    return p;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; output is registered, counts on the cycle after inc.
// No flow control: inc is sampled every cycle and ignored once the count is all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with one-entry skid buffer: one cycle in_fire->out_valid, full rate.
// Back-pressure is absorbed by the skid entry; in_ready is a flop, no combinational ready path.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int             DATA_W   = 160,
  parameter int             PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(PIPE_RESET_PC),
  parameter logic [PC_W-1:0] EXC_PC   = PC_W'(PIPE_EXC_PC),
  parameter int             CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [PC_W-1:0]   main_pc;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              req_hit;
  logic              in_fire;
  logic              out_fire;
  stage_state_t      state;

  // Only a clean 1 flushes; X/Z on req must not wipe the pipe.
  assign req_hit   = (req === 1'b1);
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign state     = stage_state(main_valid, skid_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= RESET_PC;
      main_data  <= '0;
      skid_pc    <= '0;
      skid_data  <= '0;
    end else if (req_hit) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= EXC_PC;
      main_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_valid <= 1'b1;
            main_pc    <= in_pc;
            main_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_pc   <= in_pc;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_data  <= in_data;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            skid_valid <= 1'b0;
            main_pc    <= skid_pc;
            main_data  <= skid_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (out_valid & ~out_ready & ~req_hit),
    .cnt   (stall_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (state != ST_BAD);
    end
  end

endmodule
